// File: rtl/reduce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reduce_pkg
// Description : Shared types and helpers for the reduce_tree logic reducer.
//               - mode_e      : operation select (OR/AND/XOR/NOR)
//               - identity()  : pad bit for a level with an odd bit count
//               - level_width : bits produced by tree level k
//               - level_offset: start of level k in the flattened stage vector
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package reduce_pkg;

  typedef enum logic [1:0] {
    MODE_OR  = 2'b00,
    MODE_AND = 2'b01,
    MODE_XOR = 2'b10,
    MODE_NOR = 2'b11
  } mode_e;

  // NOR runs as an OR tree, so only AND needs a 1 as its neutral element.
  function automatic logic identity(mode_e mode);
    return (mode == MODE_AND);
  endfunction

  // ceil(width / 2^(k+1)). k = -1 yields width itself, which lets the tree
  // generator describe "the level before level 0" as the raw input vector.
  function automatic int level_width(int width, int k);
    return (width + (1 << (k + 1)) - 1) >> (k + 1);
  endfunction

  // Sum of the widths of levels 0..k-1 (0 for k <= 0).
  function automatic int level_offset(int width, int k);
    int off;
    off = 0;
    for (int j = 0; j < k; j++) begin
      off += level_width(width, j);
    end
    return off;
  endfunction

endpackage : reduce_pkg
`default_nettype wire

// File: rtl/reduce_tree_if.sv
`default_nettype none
// ============================================================================
// Module      : reduce_tree_if
// Description : Valid/ready streaming bundle for reduce_tree.
//               Input side : in_valid, in_ready, in_data[WIDTH], in_mode[2]
//               Output side: out_valid, out_ready, out_bit, out_mode[2]
//               master = the environment (drives inputs, accepts results)
//               slave  = the reducer
// Revision    : 1.0 - initial release
// ============================================================================
interface reduce_tree_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic [1:0]       out_mode;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_bit, out_mode
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_bit, out_mode
  );

endinterface : reduce_tree_if
`default_nettype wire

// File: rtl/reduce_node.sv
`default_nettype none
// ============================================================================
// Module      : reduce_node
// Description : Combinational 2-input gate of the reduction tree.
//               a, b : operand bits
//               mode : operation select; NOR behaves as OR here because the
//                      inversion is applied once, at the final stage
//               y    : node result
// Revision    : 1.0 - initial release
// ============================================================================
module reduce_node
  import reduce_pkg::*;
(
  input  logic  a,
  input  logic  b,
  input  mode_e mode,
  output logic  y
);

  always_comb begin
    y = a | b;
    case (mode)
      MODE_AND: y = a & b;
      MODE_XOR: y = a ^ b;
      default:  y = a | b;
    endcase
  end

endmodule : reduce_node
`default_nettype wire

// File: rtl/reduce_tree.sv
`default_nettype none
// ============================================================================
// Module      : reduce_tree
// Description : Pipelined N-input OR/AND/XOR/NOR reducer. A balanced tree of
//               reduce_node gates with one register stage per tree level and
//               a global-stall valid/ready handshake on both sides.
// Ports       : clk    - sole clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - reduce_tree_if.slave (in_valid/in_ready/in_data/
//                        in_mode, out_valid/out_ready/out_bit/out_mode)
// Parameters  : WIDTH  - reduced bit count, 2..64
//               LEVELS - tree depth = latency, derived from WIDTH
// Revision    : 1.0 - initial release
// ============================================================================
module reduce_tree
  import reduce_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LEVELS = $clog2(WIDTH)
) (
  input  wire           clk,
  input  wire           rst_n,
  reduce_tree_if.slave  bus
);

  // All stage data registers are packed back to back: level k occupies
  // [level_offset(k) +: level_width(k)], so the final bit sits at TOTAL-1.
  localparam int TOTAL = level_offset(WIDTH, LEVELS);

  logic [TOTAL-1:0]    data_q, data_d;
  logic [LEVELS-1:0]   valid_q, valid_d;
  logic [2*LEVELS-1:0] mode_q, mode_d;

  wire  [TOTAL-1:0]    node_y;     // gate outputs, same layout as data_q
  wire  [TOTAL-1:0]    stage_en;   // source-valid replicated per stage bit
  wire  [LEVELS-1:0]   src_valid;  // valid feeding each stage
  wire  [2*LEVELS-1:0] src_mode;   // mode feeding each stage

  logic adv;

  // Global advance: the whole pipe moves whenever the output slot is free
  // or being drained this cycle.
  assign adv = !valid_q[LEVELS-1] || bus.out_ready;

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    localparam int IN_W    = level_width(WIDTH, k - 1);
    localparam int OUT_W   = level_width(WIDTH, k);
    localparam int IN_OFF  = level_offset(WIDTH, k - 1);
    localparam int OUT_OFF = level_offset(WIDTH, k);

    wire [IN_W-1:0] src_bits;
    mode_e          lvl_mode;

    if (k == 0) begin : g_from_input
      assign src_bits      = bus.in_data;
      assign src_valid[0]  = bus.in_valid;
      assign src_mode[1:0] = bus.in_mode;
    end else begin : g_from_stage
      assign src_bits           = data_q[IN_OFF +: IN_W];
      assign src_valid[k]       = valid_q[k-1];
      assign src_mode[2*k +: 2] = mode_q[2*(k-1) +: 2];
    end

    assign lvl_mode                    = mode_e'(src_mode[2*k +: 2]);
    assign stage_en[OUT_OFF +: OUT_W]  = {OUT_W{src_valid[k]}};

    for (genvar j = 0; j < OUT_W; j++) begin : g_node
      wire b_in;
      if (2*j + 1 < IN_W) begin : g_pair
        assign b_in = src_bits[2*j + 1];
      end else begin : g_pad
        assign b_in = identity(lvl_mode);
      end

      reduce_node u_node (
        .a    (src_bits[2*j]),
        .b    (b_in),
        .mode (lvl_mode),
        .y    (node_y[OUT_OFF + j])
      );
    end
  end

  always_comb begin
    valid_d = valid_q;
    mode_d  = mode_q;
    data_d  = data_q;
    if (adv) begin
      valid_d = src_valid;
      // Bubbles carry zeroed mode and data so waveforms stay readable.
      for (int k = 0; k < LEVELS; k++) begin
        mode_d[2*k +: 2] = src_valid[k] ? src_mode[2*k +: 2] : 2'b00;
      end
      data_d = node_y & stage_en;
      // NOR is an OR tree up to here; invert only when loading the output.
      if (src_mode[2*LEVELS-1 -: 2] == MODE_NOR) begin
        data_d[TOTAL-1] = !node_y[TOTAL-1] && stage_en[TOTAL-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      mode_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_q[LEVELS-1];
  assign bus.out_bit   = data_q[TOTAL-1];
  assign bus.out_mode  = mode_q[2*LEVELS-1 -: 2];

endmodule : reduce_tree
`default_nettype wire

// File: tb/tb_reduce_tree.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_reduce_tree
// Description : Self-checking bench for reduce_tree. Four instances
//               (WIDTH 8, 5, 3, 2) share clock and reset; per-instance
//               drivers push expected results into one scoreboard queue and a
//               single negedge monitor pops and compares each output beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reduce_tree;
  import reduce_pkg::*;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Per-instance stimulus (index 0..3 = WIDTH 8, 5, 3, 2)
  logic [NI-1:0] v_valid;
  logic [NI-1:0] v_ordy;
  logic [63:0]   v_data [NI];
  logic [1:0]    v_mode [NI];
  logic [NI-1:0] lat_en;
  logic [NI-1:0] rnd_ordy;

  wire [NI-1:0]   ir, ov, ob;
  wire [2*NI-1:0] om;

  reduce_tree_if #(.WIDTH(8)) bus8 ();
  reduce_tree_if #(.WIDTH(5)) bus5 ();
  reduce_tree_if #(.WIDTH(3)) bus3 ();
  reduce_tree_if #(.WIDTH(2)) bus2 ();

  assign bus8.in_valid = v_valid[0]; assign bus8.in_data = v_data[0][7:0];
  assign bus8.in_mode  = v_mode[0];  assign bus8.out_ready = v_ordy[0];
  assign bus5.in_valid = v_valid[1]; assign bus5.in_data = v_data[1][4:0];
  assign bus5.in_mode  = v_mode[1];  assign bus5.out_ready = v_ordy[1];
  assign bus3.in_valid = v_valid[2]; assign bus3.in_data = v_data[2][2:0];
  assign bus3.in_mode  = v_mode[2];  assign bus3.out_ready = v_ordy[2];
  assign bus2.in_valid = v_valid[3]; assign bus2.in_data = v_data[3][1:0];
  assign bus2.in_mode  = v_mode[3];  assign bus2.out_ready = v_ordy[3];

  assign ir = {bus2.in_ready,  bus3.in_ready,  bus5.in_ready,  bus8.in_ready};
  assign ov = {bus2.out_valid, bus3.out_valid, bus5.out_valid, bus8.out_valid};
  assign ob = {bus2.out_bit,   bus3.out_bit,   bus5.out_bit,   bus8.out_bit};
  assign om = {bus2.out_mode,  bus3.out_mode,  bus5.out_mode,  bus8.out_mode};

  reduce_tree #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  reduce_tree #(.WIDTH(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));
  reduce_tree #(.WIDTH(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  reduce_tree #(.WIDTH(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  // ---------------------------------------------------------------- helpers
  int n_chk  = 0;
  int n_fail = 0;

  function automatic int wid(int i);
    case (i)
      0:       return 8;
      1:       return 5;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  // Reference reduction straight from the definition of each operation.
  function automatic logic model(logic [63:0] d, logic [1:0] m, int w);
    logic [63:0] mask;
    logic [63:0] x;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    x    = d & mask;
    case (m)
      2'b00:   return (x != 0);
      2'b01:   return (x == mask);
      2'b10:   return ($countones(x) % 2) == 1;
      default: return (x == 0);
    endcase
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(string name, string what);
    n_chk  = n_chk + 1;
    n_fail = n_fail + 1;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  typedef struct {
    int         inst;
    logic       b;
    logic [1:0] m;
    int         cyc;
    bit         lat;
  } exp_t;

  exp_t sb[$];

  function automatic int pending(int i);
    int n;
    n = 0;
    foreach (sb[k]) if (sb[k].inst == i) n++;
    return n;
  endfunction

  task automatic wait_cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(int i);
    v_valid[i] = 1'b0;
  endtask

  // Present one vector and hold it until accepted; the expected result is
  // queued at the moment the transfer is seen.
  task automatic xfer(int i, logic [63:0] d, logic [1:0] m, logic e);
    bit   acc;
    int   tmo;
    exp_t x;
    acc = 0;
    tmo = 0;
    v_valid[i] = 1'b1;
    v_data[i]  = d;
    v_mode[i]  = m;
    while (!acc) begin
      @(negedge clk);
      if (ir[i]) begin
        acc   = 1;
        x.inst = i; x.b = e; x.m = m; x.cyc = cyc; x.lat = lat_en[i];
        sb.push_back(x);
      end
      @(posedge clk);
      #1;
      if (!acc) begin
        tmo = tmo + 1;
        if (tmo > 100) begin
          fail_now($sformatf("w%0d_accept", wid(i)), "in_ready never rose, required acceptance");
          return;
        end
      end
    end
  endtask

  task automatic rand_stream(int i, int n);
    for (int k = 0; k < n; k++) begin
      logic [63:0] d;
      logic [1:0]  m;
      int          sel;
      sel = $urandom_range(0, 5);
      d   = (sel == 0) ? '1 : (sel == 1) ? 64'd0 : {$urandom, $urandom};
      m   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        idle(i);
        wait_cycles(1);
      end
      xfer(i, d, m, model(d, m, wid(i)));
    end
    idle(i);
  endtask

  // --------------------------------------------------------------- monitor
  logic [NI-1:0]   pstall = '0;
  logic [NI-1:0]   pbit   = '0;
  logic [2*NI-1:0] pmode  = '0;

  task automatic pop(int i);
    int   idx;
    exp_t e;
    idx = -1;
    foreach (sb[k]) if (idx < 0 && sb[k].inst == i) idx = k;
    if (idx < 0) begin
      fail_now($sformatf("w%0d_unexpected_out", wid(i)),
               $sformatf("out_valid with bit %0b, required no output", ob[i]));
    end else begin
      e = sb[idx];
      sb.delete(idx);
      chk($sformatf("w%0d_out_bit", wid(i)), 64'(ob[i]), 64'(e.b));
      chk($sformatf("w%0d_out_mode", wid(i)), 64'(om[2*i +: 2]), 64'(e.m));
      if (e.lat) chk($sformatf("w%0d_latency", wid(i)), 64'(cyc - e.cyc), 64'($clog2(wid(i))));
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      pstall = '0;
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (pstall[i]) begin
          chk($sformatf("w%0d_stall_valid", wid(i)), 64'(ov[i]), 64'd1);
          chk($sformatf("w%0d_stall_bit", wid(i)), 64'(ob[i]), 64'(pbit[i]));
          chk($sformatf("w%0d_stall_mode", wid(i)), 64'(om[2*i +: 2]), 64'(pmode[2*i +: 2]));
        end
        if (ov[i] && !v_ordy[i]) chk($sformatf("w%0d_stall_in_ready", wid(i)), 64'(ir[i]), 64'd0);
        if (ov[i] && v_ordy[i]) pop(i);
        pstall[i]         = ov[i] && !v_ordy[i];
        pbit[i]           = ob[i];
        pmode[2*i +: 2]   = om[2*i +: 2];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NI; i++) begin
      if (rnd_ordy[i]) v_ordy[i] = ($urandom_range(0, 3) != 0);
    end
  end

  // --------------------------------------------------------- directed data
  logic [7:0] t1_data [6] = '{8'h00, 8'h10, 8'hFF, 8'hFE, 8'h07, 8'h00};
  logic [1:0] t1_mode [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
  logic       t1_exp  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  logic [7:0] t2_data [4] = '{8'h01, 8'h01, 8'h03, 8'h01};
  logic [1:0] t2_mode [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic       t2_exp  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  logic [4:0] t3_data [3] = '{5'h1F, 5'h10, 5'h10};
  logic [1:0] t3_mode [3] = '{2'b01, 2'b00, 2'b10};
  logic       t3_exp  [3] = '{1'b1, 1'b1, 1'b1};

  // ---------------------------------------------------------------- stimulus
  initial begin
    v_valid  = '0;
    v_ordy   = '1;
    lat_en   = '0;
    rnd_ordy = '0;
    for (int i = 0; i < NI; i++) begin
      v_data[i] = '0;
      v_mode[i] = 2'b00;
    end

    rst_n = 1'b0;
    wait_cycles(3);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("w%0d_reset_out_valid", wid(i)), 64'(ov[i]), 64'd0);
      chk($sformatf("w%0d_reset_out_bit", wid(i)), 64'(ob[i]), 64'd0);
      chk($sformatf("w%0d_reset_out_mode", wid(i)), 64'(om[2*i +: 2]), 64'd0);
      chk($sformatf("w%0d_reset_in_ready", wid(i)), 64'(ir[i]), 64'd1);
    end
    rst_n = 1'b1;
    wait_cycles(2);

    // Isolated vectors on WIDTH=8
    lat_en = '1;
    for (int n = 0; n < 6; n++) begin
      xfer(0, 64'(t1_data[n]), t1_mode[n], t1_exp[n]);
      idle(0);
      wait_cycles(5);
    end

    // Back-to-back mixed modes on WIDTH=8
    for (int n = 0; n < 4; n++) xfer(0, 64'(t2_data[n]), t2_mode[n], t2_exp[n]);
    idle(0);
    wait_cycles(6);

    // Padding identities on WIDTH=5
    for (int n = 0; n < 3; n++) xfer(1, 64'(t3_data[n]), t3_mode[n], t3_exp[n]);
    idle(1);
    wait_cycles(6);

    // Exhaustive WIDTH=3
    for (int m = 0; m < 4; m++) begin
      for (int d = 0; d < 8; d++) begin
        xfer(2, 64'(d), 2'(m), model(64'(d), 2'(m), 3));
      end
    end
    idle(2);
    wait_cycles(6);

    // Backpressure on WIDTH=8: 10 vectors, out_ready low for 4 cycles
    lat_en = '0;
    fork
      begin
        for (int n = 0; n < 10; n++) begin
          logic [63:0] d;
          logic [1:0]  m;
          d = 64'($urandom_range(0, 255));
          m = 2'($urandom_range(0, 3));
          xfer(0, d, m, model(d, m, 8));
        end
        idle(0);
      end
      begin
        wait_cycles(4);
        v_ordy[0] = 1'b0;
        wait_cycles(4);
        v_ordy[0] = 1'b1;
      end
    join
    wait_cycles(10);
    chk("w8_backpressure_drained", 64'(pending(0)), 64'd0);

    // Randomised traffic with random backpressure on all widths
    rnd_ordy = '1;
    fork
      rand_stream(0, 40);
      rand_stream(1, 40);
      rand_stream(2, 40);
      rand_stream(3, 40);
    join
    rnd_ordy = '0;
    v_ordy   = '1;
    wait_cycles(10);
    for (int i = 0; i < NI; i++) chk($sformatf("w%0d_random_drained", wid(i)), 64'(pending(i)), 64'd0);

    // Reset with three vectors in flight on WIDTH=8
    for (int n = 0; n < 3; n++) xfer(0, 64'hFF, 2'b00, 1'b1);
    idle(0);
    #1 rst_n = 1'b0;
    #1;
    chk("w8_midreset_out_valid", 64'(ov[0]), 64'd0);
    chk("w8_midreset_out_bit", 64'(ob[0]), 64'd0);
    chk("w8_midreset_in_ready", 64'(ir[0]), 64'd1);
    sb.delete();
    #1 rst_n = 1'b1;
    wait_cycles(8);
    chk("w8_postreset_out_valid", 64'(ov[0]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required end of test");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_reduce_tree
`default_nettype wire
